// File: rtl/alu_operand_issue_if.sv
// rtl/alu_operand_issue_if.sv - Handshake bundle between register-file read, operand issue and the adder
interface alu_operand_issue_if #(
  parameter int W     = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [W-1:0]     in_rs;
  logic [W-1:0]     in_rt;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_a;
  logic [W-1:0]     out_b;
  logic             out_cin;
  logic             out_wr;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_tag, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_cin, out_wr, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_tag, out_ready,
    output in_ready, out_valid, out_a, out_b, out_cin, out_wr, out_tag
  );
endinterface

// File: rtl/alu_operand_issue.sv
// rtl/alu_operand_issue.sv - Maps ALU opcodes onto registered adder a/b/cin with back-pressure buffering
// Defining ALU_ISSUE_SKID_EN adds a two-entry skid buffer with a registered in_ready.
module alu_operand_issue #(
  parameter int W     = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_operand_issue_if.slave bus,
  output logic [7:0]         illegal_cnt
);
  localparam int EW = 2 * W + 2 + TAG_W;  // packed entry {a, b, cin, wr, tag}

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] out_q, out_d;
  logic [EW-1:0] map_e;
  logic [7:0]    illegal_q, illegal_d;
  logic          accept;
  logic          drain;

  always_comb begin : opcode_map
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         wr;
    a   = bus.in_rs;
    b   = '0;
    cin = 1'b0;
    wr  = 1'b1;
    case (bus.in_op)
      3'b000: b = bus.in_rt;
      3'b001: begin b = ~bus.in_rt; cin = 1'b1; end
      3'b010: cin = 1'b1;
      3'b011: b = '1;
      3'b100: begin a = '0; b = ~bus.in_rs; cin = 1'b1; end
      3'b101: b = '0;
      3'b110: begin b = ~bus.in_rt; cin = 1'b1; wr = 1'b0; end
      default: begin b = bus.in_rt; wr = 1'b0; end
    endcase
    map_e = {a, b, cin, wr, bus.in_tag};
  end

  assign accept        = bus.in_valid && bus.in_ready;
  assign drain         = bus.out_valid && bus.out_ready;
  assign bus.out_valid = (state_q != EMPTY);
  assign {bus.out_a, bus.out_b, bus.out_cin, bus.out_wr, bus.out_tag} = out_q;

`ifdef ALU_ISSUE_SKID_EN
  logic [EW-1:0] skid_q, skid_d;
  logic          in_ready_q;

  assign bus.in_ready = in_ready_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (accept) begin state_d = ONE; out_d = map_e; end
      ONE: begin
        if (accept && drain) begin
          out_d = map_e;
        end else if (accept) begin
          state_d = TWO;
          skid_d  = map_e;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: if (drain) begin state_d = ONE; out_d = skid_q; end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready looks one state ahead so it is a flop, not a path from out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      skid_q     <= skid_d;
      in_ready_q <= (state_d != TWO);
    end
  end
`else
  assign bus.in_ready = !bus.out_valid || bus.out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    if (accept) begin
      state_d = ONE;
      out_d   = map_e;
    end else if (drain) begin
      state_d = EMPTY;
    end
  end
`endif

  always_comb begin
    illegal_d = illegal_q;
    if (accept && (bus.in_op == 3'b111) && (illegal_q != 8'hFF)) begin
      illegal_d = illegal_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      out_q     <= '0;
      illegal_q <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal_cnt = illegal_q;
endmodule

// File: tb/tb_alu_operand_issue.sv
// tb/tb_alu_operand_issue.sv - Directed vectors and a reference-queue scoreboard for alu_operand_issue
module tb_alu_operand_issue;
  localparam int W     = 16;
  localparam int TAG_W = 4;
  localparam int NRAND = 10000;
`ifdef ALU_ISSUE_SKID_EN
  localparam int HOLD_ACC = 2;
`else
  localparam int HOLD_ACC = 1;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] illegal_cnt;
  int         total = 0;
  int         bad   = 0;

  logic [2:0]  b2b_op  [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
  logic [33:0] b2b_exp [6] = '{
    {16'h7FFF, 16'h0001, 1'b0, 1'b1},
    {16'h7FFF, 16'h0000, 1'b1, 1'b1},
    {16'h7FFF, 16'hFFFF, 1'b0, 1'b1},
    {16'h0000, 16'h8000, 1'b1, 1'b1},
    {16'h7FFF, 16'h0000, 1'b0, 1'b1},
    {16'h7FFF, 16'hFFFE, 1'b1, 1'b0}
  };

  logic [15:0] sum;
  int          acc_n;
  logic [3:0]  drn_tags[$];
  logic [37:0] sbq[$];
  logic [37:0] held;
  logic        hold;
  int          sent;
  int          got;

  alu_operand_issue_if #(.W(W), .TAG_W(TAG_W)) bus ();

  alu_operand_issue #(.W(W), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] model(input logic [2:0] op, input logic [15:0] rs,
                                        input logic [15:0] rt, input logic [3:0] tag);
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        wr;
    case (op)
      3'd0:    begin a = rs;    b = rt;       cin = 1'b0; wr = 1'b1; end
      3'd1:    begin a = rs;    b = ~rt;      cin = 1'b1; wr = 1'b1; end
      3'd2:    begin a = rs;    b = 16'h0000; cin = 1'b1; wr = 1'b1; end
      3'd3:    begin a = rs;    b = 16'hFFFF; cin = 1'b0; wr = 1'b1; end
      3'd4:    begin a = 16'h0; b = ~rs;      cin = 1'b1; wr = 1'b1; end
      3'd5:    begin a = rs;    b = 16'h0000; cin = 1'b0; wr = 1'b1; end
      3'd6:    begin a = rs;    b = ~rt;      cin = 1'b1; wr = 1'b0; end
      default: begin a = rs;    b = rt;       cin = 1'b0; wr = 1'b0; end
    endcase
    return {a, b, cin, wr, tag};
  endfunction

  function automatic logic [37:0] out_e();
    return {bus.out_a, bus.out_b, bus.out_cin, bus.out_wr, bus.out_tag};
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] rs,
                       input logic [15:0] rt, input logic [3:0] tag, input logic rdy);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_tag    = tag;
    bus.out_ready = rdy;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_rs     = '0;
    bus.in_rt     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    after_edge();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_outputs",   64'(out_e()),       64'd0);
    check("rst_illegal",   64'(illegal_cnt),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 3'b001, 16'h0005, 16'h0003, 4'd2, 1'b1);
    after_edge();
    check("sub_valid", 64'(bus.out_valid), 64'd1);
    check("sub_entry", 64'(out_e()), 64'({16'h0005, 16'hFFFC, 1'b1, 1'b1, 4'd2}));
    sum = bus.out_a + bus.out_b + 16'(bus.out_cin);
    check("sub_sum", 64'(sum), 64'h0002);

    for (int i = 0; i < 6; i++) begin
      drive(1'b1, b2b_op[i], 16'h7FFF, 16'h0001, 4'(i + 8), 1'b1);
      after_edge();
      check("b2b_valid", 64'(bus.out_valid), 64'd1);
      check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
      check("b2b_abcw", 64'({bus.out_a, bus.out_b, bus.out_cin, bus.out_wr}), 64'(b2b_exp[i]));
      check("b2b_tag", 64'(bus.out_tag), 64'(i + 8));
      if (i == 0) begin
        sum = bus.out_a + bus.out_b + 16'(bus.out_cin);
        check("add_sum", 64'(sum), 64'h8000);
        check("add_ovf", 64'((bus.out_a[15] == bus.out_b[15]) && (sum[15] != bus.out_a[15])), 64'd1);
      end
    end
    drive(1'b0, 3'd0, 16'h0, 16'h0, 4'd0, 1'b1);
    after_edge();
    check("b2b_idle", 64'(bus.out_valid), 64'd0);

    // Stalled downstream: upstream keeps offering its current op until taken
    acc_n = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      drive(acc_n < 3, 3'd0, 16'(acc_n), 16'h0010, 4'(5 + acc_n), 1'b0);
      #3;
      if (bus.in_valid && bus.in_ready) acc_n++;
    end
    check("bp_accepted", 64'(acc_n), 64'(HOLD_ACC));
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_held", 64'(out_e()), 64'({16'h0000, 16'h0010, 1'b0, 1'b1, 4'd5}));
    for (int cyc = 0; cyc < 20 && drn_tags.size() < 3; cyc++) begin
      drive(acc_n < 3, 3'd0, 16'(acc_n), 16'h0010, 4'(5 + acc_n), 1'b1);
      #3;
      if (bus.out_valid && bus.out_ready) drn_tags.push_back(bus.out_tag);
      if (bus.in_valid && bus.in_ready) acc_n++;
    end
    check("bp_drained", 64'(drn_tags.size()), 64'd3);
    for (int i = 0; i < drn_tags.size(); i++) check("bp_order", 64'(drn_tags[i]), 64'(5 + i));
    drive(1'b0, 3'd0, 16'h0, 16'h0, 4'd0, 1'b1);
    after_edge();
    check("bp_no_dup", 64'(bus.out_valid), 64'd0);

    check("cnt_legal_only", 64'(illegal_cnt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b111, 16'h1234, 16'h0011, 4'(i), 1'b1);
      after_edge();
      check("rsv_entry", 64'(out_e()), 64'({16'h1234, 16'h0011, 1'b0, 1'b0, 4'(i)}));
    end
    check("cnt_three", 64'(illegal_cnt), 64'd3);
    for (int i = 0; i < 251; i++) drive(1'b1, 3'b111, 16'h0, 16'h0, 4'd0, 1'b1);
    after_edge();
    check("cnt_254", 64'(illegal_cnt), 64'd254);
    for (int i = 0; i < 49; i++) drive(1'b1, 3'b111, 16'h0, 16'h0, 4'd0, 1'b1);
    after_edge();
    check("cnt_sat", 64'(illegal_cnt), 64'd255);
    drive(1'b0, 3'd0, 16'h0, 16'h0, 4'd0, 1'b1);
    after_edge();

    drive(1'b1, 3'd0, 16'h1111, 16'h2222, 4'hA, 1'b0);
    drive(1'b1, 3'd0, 16'h3333, 16'h4444, 4'hB, 1'b0);
    drive(1'b0, 3'd0, 16'h0, 16'h0, 4'd0, 1'b0);
    #3;
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    check("pre_rst_in_ready", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_outputs", 64'(out_e()), 64'd0);
    check("mid_rst_illegal", 64'(illegal_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 16'h0, 16'h0, 4'd0, 1'b1);
    after_edge();
    check("post_rst_idle0", 64'(bus.out_valid), 64'd0);
    after_edge();
    check("post_rst_idle1", 64'(bus.out_valid), 64'd0);
    drive(1'b1, 3'd0, 16'h0100, 16'h0023, 4'h9, 1'b1);
    after_edge();
    check("post_rst_entry", 64'(out_e()), 64'({16'h0100, 16'h0023, 1'b0, 1'b1, 4'h9}));
    drive(1'b0, 3'd0, 16'h0, 16'h0, 4'd0, 1'b1);
    after_edge();
    check("post_rst_no_stale", 64'(bus.out_valid), 64'd0);

    sent = 0;
    got  = 0;
    hold = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 60000 && got < NRAND; cyc++) begin
      @(negedge clk);
      bus.in_valid  = (sent < NRAND) && ($urandom_range(0, 9) < 7);
      bus.in_op     = 3'($urandom_range(0, 7));
      bus.in_rs     = 16'($urandom);
      bus.in_rt     = 16'($urandom);
      bus.in_tag    = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      #3;
      if (hold) check("rand_stable", 64'(out_e()), 64'(held));
      if (bus.out_valid && bus.out_ready) begin
        check("rand_q_nonempty", 64'(sbq.size() > 0), 64'd1);
        if (sbq.size() > 0) check("rand_order", 64'(out_e()), 64'(sbq.pop_front()));
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        sbq.push_back(model(bus.in_op, bus.in_rs, bus.in_rt, bus.in_tag));
        sent++;
      end
      hold = bus.out_valid && !bus.out_ready;
      held = out_e();
    end
    check("rand_drained", 64'(got), 64'(NRAND));
    check("rand_q_empty", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_operand_issue.md
# alu_operand_issue

Operand issue stage sitting directly upstream of the 16-bit ripple adder in the ALU datapath. Accepts decoded ALU operations (opcode, two register-file operands, destination tag) over a valid/ready handshake, maps each opcode onto the adder's `a`, `b`, and `cin` inputs, and presents them from registers so the adder sees stable operands for a full cycle. Provides back-pressure buffering so the register-file read stage never drops an operation when the downstream result stage stalls.

## Interface
- `W`, default 16: operand width; must match the adder width.
- `TAG_W`, default 4: destination register tag width (16-entry register file).
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: upstream operation valid.
- `in_ready`, output, 1: stage can accept an operation.
- `in_op`, input, 3: opcode.
- `in_rs`, input, W: operand A from the register file.
- `in_rt`, input, W: operand B from the register file.
- `in_tag`, input, TAG_W: destination register.
- `out_valid`, output, 1: issued operands valid.
- `out_ready`, input, 1: downstream (adder/result stage) accepts.
- `out_a`, output, W: adder `a` input.
- `out_b`, output, W: adder `b` input.
- `out_cin`, output, 1: adder carry-in.
- `out_wr`, output, 1: result is written back (0 for CMP).
- `out_tag`, output, TAG_W: destination tag passed through.
- `illegal_cnt`, output, 8: saturating count of reserved opcodes accepted.

## Operation
- Transfer occurs on a rising edge where `valid && ready` is high on that interface.
- Opcode mapping (a, b, cin, wr):
  - 000 ADD: rs, rt, 0, 1.
  - 001 SUB: rs, ~rt, 1, 1.
  - 010 INC: rs, 0, 1, 1.
  - 011 DEC: rs, all-ones, 0, 1.
  - 100 NEG: 0, ~rs, 1, 1.
  - 101 PASS: rs, 0, 0, 1.
  - 110 CMP: rs, ~rt, 1, 0.
  - 111 reserved: issued as ADD with `out_wr`=0; `illegal_cnt` increments and saturates at 255.
- All mapped values are registered. No combinational path exists from `in_*` to `out_a`, `out_b`, `out_cin`, `out_wr`, or `out_tag`.
- Buffer states:
  - EMPTY: `out_valid`=0.
  - ONE: output register holds the entry.
  - TWO: output register and skid register both hold entries. TWO exists only with the skid buffer configured.
- Transitions:
  - EMPTY→ONE on accept.
  - ONE→EMPTY on drain without accept.
  - ONE stays ONE on simultaneous accept and drain.
  - ONE→TWO on accept while `out_ready`=0.
  - TWO→ONE on drain; the skid entry moves into the output register.
- Ordering is strictly FIFO. Output register contents are held stable while `out_valid && !out_ready`.
- Reset values: `out_valid`=0, `in_ready`=1, `out_a`/`out_b`=0, `out_cin`=0, `out_wr`=0, `out_tag`=0, `illegal_cnt`=0, state EMPTY.
- Reset mid-operation discards all buffered entries and takes effect immediately (asynchronous); nothing issues afterwards until a new accept.

## Timing
- Latency: an operation accepted at edge N has `out_valid`=1 from edge N (visible in the cycle after N); one cycle through the stage.
- Throughput: one operation per cycle while `out_ready`=1.
- With skid buffer: `in_ready` is registered and equals (state != TWO). A drain in TWO raises `in_ready` on the following cycle.
- Without skid buffer: `in_ready` = !`out_valid` || `out_ready` (combinational from `out_ready`).
- `illegal_cnt` updates on the edge the reserved opcode is accepted, not when it is issued.

## Configuration
- `ALU_ISSUE_SKID_EN` defined: two-entry skid buffer. `in_ready` is fully registered and breaks the ready timing path back to the register-file stage.
- `ALU_ISSUE_SKID_EN` undefined: single output register, combinational `in_ready`. Same throughput, no TWO state.
- Opcode mapping, latency, and reset behaviour are identical in both builds.

## Test plan
- Reset, then SUB rs=0x0005, rt=0x0003, tag=2 with `out_ready`=1. Expected: next cycle `out_a`=0x0005, `out_b`=0xFFFC, `out_cin`=1, `out_wr`=1, `out_tag`=2; adder sum 0x0002.
- Back-to-back ADD, INC, DEC, NEG, PASS, CMP with rs=0x7FFF, rt=0x0001 and `out_ready`=1. Expected: six consecutive issues in order. ADD gives adder overflow 1 (sum 0x8000). CMP gives `out_wr`=0.
- Hold `out_ready`=0 and offer 3 operations. With skid: 2 accepted and `in_ready`=0 afterwards. Without skid: 1 accepted. Raise `out_ready`: operations drain in order with no loss or duplication.
- Issue opcode 111 three times. Expected: `illegal_cnt`=3, each issued with `out_wr`=0. Force 300 reserved ops: count holds at 255.
- Assert `rst_n`=0 while in TWO (skid build). Expected: `out_valid`=0 and `in_ready`=1 immediately. After release, the first new op issues with correct values and nothing stale appears.
- Random valid/ready toggling, 10k operations, checked against a reference queue. Expected: no drops, no reorders, and `out_*` stable whenever `out_valid && !out_ready`.
